// File: rtl/march_sequencer_pkg.sv
// Shared types and defaults for the march program sequencer.
// The state encoding is the 3-bit register image that the FSM and any debug tap use.
package march_sequencer_pkg;

  localparam int SEQ_AW = 8;
  localparam int SEQ_PW = 4;
  localparam int SEQ_NW = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // An element closes the program if it is flagged last or sits in the top ROM slot.
  function automatic logic program_ends(input logic last_flag, input logic pm_at_max);
    return last_flag | pm_at_max;
  endfunction

endpackage

// File: rtl/march_addr_counter.sv
// Up/down memory address counter for one march element.
// Loads to the direction's start address, steps on enable, and flags the terminal address.
module march_addr_counter
  import march_sequencer_pkg::*;
#(
  parameter int AW = SEQ_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic          up,
  output logic [AW-1:0] addr,
  output logic          at_end
);

  localparam logic [AW-1:0] ADDR_MAX  = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] addr_r;

  assign addr = addr_r;

  // Terminal compare is taken before any step so the counter never wraps.
  always_comb begin
    at_end = 1'b0;
    if (up) begin
      at_end = (addr_r == ADDR_MAX);
    end else begin
      at_end = (addr_r == ADDR_ZERO);
    end
  end

  // Address register: load has priority over step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_r <= ADDR_ZERO;
    end else if (load) begin
      addr_r <= up ? ADDR_ZERO : ADDR_MAX;
    end else if (step) begin
      addr_r <= up ? (addr_r + ADDR_ONE) : (addr_r - ADDR_ONE);
    end else begin
      addr_r <= addr_r;
    end
  end

endmodule

// File: rtl/march_sequencer.sv
// Walks a march program from a synchronous ROM, loading each element into the IR
// and issuing (nops+1) op slots per memory address in the element's direction.
module march_sequencer
  import march_sequencer_pkg::*;
#(
  parameter int AW = SEQ_AW,
  parameter int PW = SEQ_PW,
  parameter int NW = SEQ_NW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [PW-1:0] pm_addr,
  input  logic          pm_updwn,
  input  logic [NW-1:0] pm_nops,
  input  logic          pm_last,
  output logic          ir_hold,
  output logic [AW-1:0] mem_addr,
  output logic [NW-1:0] op_idx,
  output logic          op_valid,
  output logic          busy,
  output logic          done
);

  localparam logic [PW-1:0] PM_MAX  = {PW{1'b1}};
  localparam logic [PW-1:0] PM_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PM_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [NW-1:0] OP_ZERO = {NW{1'b0}};
  localparam logic [NW-1:0] OP_ONE  = {{(NW-1){1'b0}}, 1'b1};

  seq_state_e    state_r;
  logic          updwn_r;
  logic [NW-1:0] nops_r;
  logic          last_r;

  logic          at_end_s;
  logic          cnt_load_s;
  logic          cnt_step_s;
  logic          cnt_dir_s;
  logic          slot_last_s;

  assign slot_last_s = (op_idx == nops_r);

  // Counter control: LOAD takes direction straight from the ROM since it is not latched yet.
  always_comb begin
    cnt_load_s = 1'b0;
    cnt_step_s = 1'b0;
    cnt_dir_s  = updwn_r;
    if (state_r == ST_LOAD) begin
      cnt_load_s = 1'b1;
      cnt_dir_s  = pm_updwn;
    end else if ((state_r == ST_RUN) && slot_last_s && !at_end_s) begin
      cnt_step_s = 1'b1;
    end else begin
      cnt_load_s = 1'b0;
      cnt_step_s = 1'b0;
    end
  end

  march_addr_counter #(
    .AW(AW)
  ) u_addr_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load_s),
    .step   (cnt_step_s),
    .up     (cnt_dir_s),
    .addr   (mem_addr),
    .at_end (at_end_s)
  );

  // Sequencer FSM; each output is registered with the value belonging to the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      pm_addr  <= PM_ZERO;
      op_idx   <= OP_ZERO;
      updwn_r  <= 1'b0;
      nops_r   <= OP_ZERO;
      last_r   <= 1'b0;
      ir_hold  <= 1'b1;
      op_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      ir_hold  <= 1'b1;
      op_valid <= 1'b0;
      done     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_FETCH;
            pm_addr <= PM_ZERO;
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_FETCH: begin
          state_r <= ST_LOAD;
          ir_hold <= 1'b0;
          busy    <= 1'b1;
        end
        ST_LOAD: begin
          updwn_r  <= pm_updwn;
          nops_r   <= pm_nops;
          last_r   <= pm_last;
          op_idx   <= OP_ZERO;
          state_r  <= ST_RUN;
          op_valid <= 1'b1;
          busy     <= 1'b1;
        end
        ST_RUN: begin
          busy <= 1'b1;
          if (!slot_last_s) begin
            op_idx   <= op_idx + OP_ONE;
            op_valid <= 1'b1;
            state_r  <= ST_RUN;
          end else begin
            op_idx <= OP_ZERO;
            if (!at_end_s) begin
              op_valid <= 1'b1;
              state_r  <= ST_RUN;
            end else if (program_ends(last_r, pm_addr == PM_MAX)) begin
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              pm_addr <= pm_addr + PM_ONE;
              state_r <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_march_sequencer.sv
// Directed bench for march_sequencer with AW=2, PW=2 and a behavioural synchronous ROM.
module tb_march_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] pm_addr;
  logic       pm_updwn;
  logic [1:0] pm_nops;
  logic       pm_last;
  logic       ir_hold;
  logic [1:0] mem_addr;
  logic [1:0] op_idx;
  logic       op_valid;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_fail = 0;

  logic       rom_up   [4];
  logic [1:0] rom_nops [4];
  logic       rom_last [4];

  march_sequencer #(.AW(2), .PW(2), .NW(2)) dut (
    .clk(clk), .rst(rst), .start(start), .pm_addr(pm_addr),
    .pm_updwn(pm_updwn), .pm_nops(pm_nops), .pm_last(pm_last),
    .ir_hold(ir_hold), .mem_addr(mem_addr), .op_idx(op_idx),
    .op_valid(op_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program ROM: data appears the cycle after the address.
  always @(posedge clk) begin
    pm_updwn <= rom_up[pm_addr];
    pm_nops  <= rom_nops[pm_addr];
    pm_last  <= rom_last[pm_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rom(input int idx, input logic up, input logic [1:0] nops, input logic last);
    rom_up[idx]   = up;
    rom_nops[idx] = nops;
    rom_last[idx] = last;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4; i++) set_rom(i, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    rst = 1'b0;
    start = 1'b0;
    tick();
    tick();
    obs = {pm_addr, mem_addr, op_idx, ir_hold, op_valid, busy, done};
    n_cmp++;
    if (obs !== 10'b00_00_00_1_0_0_0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs, 10'b00_00_00_1_0_0_0);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_up();
    logic [3:0] obs;
    logic [3:0] exp;
    clear_rom();
    set_rom(0, 1'b1, 2'd0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, ir_hold, op_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL up_fetch: got busy/hold/valid=%b expected 110", {busy, ir_hold, op_valid});
    end
    tick();
    n_cmp++;
    if ({ir_hold, op_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL up_load: got hold/valid=%b expected 00", {ir_hold, op_valid});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      obs = {op_valid, mem_addr, done};
      exp = {1'b1, 2'(i), 1'b0};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL up_run[%0d]: got valid/addr/done=%b expected %b", i, obs, exp);
      end
    end
    tick();
    n_cmp++;
    if ({done, op_valid, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL up_done: got done/valid/busy=%b expected 101", {done, op_valid, busy});
    end
    tick();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL up_idle: got done/busy=%b expected 00", {done, busy});
    end
  endtask

  task automatic test_down_two_ops();
    logic [4:0] obs;
    logic [4:0] exp;
    clear_rom();
    set_rom(0, 1'b0, 2'd1, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      obs = {op_valid, mem_addr, op_idx};
      exp = {1'b1, 2'(3 - i / 2), 2'(i % 2)};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL down_run[%0d]: got valid/addr/op=%b expected %b", i, obs, exp);
      end
    end
    tick();
    n_cmp++;
    if ({done, op_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL down_done: got done/valid=%b expected 10", {done, op_valid});
    end
    tick();
  endtask

  task automatic test_two_elements();
    logic [4:0] obs;
    logic [4:0] exp;
    logic [1:0] exp_addr;
    logic       exp_ov;
    int         hold_lows;
    clear_rom();
    set_rom(0, 1'b1, 2'd0, 1'b0);
    set_rom(1, 1'b0, 2'd0, 1'b1);
    hold_lows = 0;
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start = 1'b0;
      exp_ov = ((c >= 3) && (c <= 6)) || ((c >= 9) && (c <= 12));
      exp = {exp_ov, !((c == 2) || (c == 8)), (c >= 7) ? 2'd1 : 2'd0, (c == 13)};
      obs = {op_valid, ir_hold, pm_addr, done};
      if (!ir_hold) hold_lows++;
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL two_elem_c%0d: got valid/hold/pm/done=%b expected %b", c, obs, exp);
      end
      if (exp_ov) begin
        exp_addr = (c <= 6) ? 2'(c - 3) : 2'(12 - c);
        n_cmp++;
        if (mem_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL two_elem_addr_c%0d: got %0d expected %0d", c, mem_addr, exp_addr);
        end
      end
    end
    n_cmp++;
    if (hold_lows != 2) begin
      n_fail++;
      $display("FAIL two_elem_hold_count: got %0d expected 2", hold_lows);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [9:0] obs;
    int ops;
    int saw_done;
    clear_rom();
    set_rom(0, 1'b1, 2'd0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if ({op_valid, mem_addr} !== 3'b110) begin
      n_fail++;
      $display("FAIL abort_pre: got valid/addr=%b expected 110", {op_valid, mem_addr});
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    obs = {pm_addr, mem_addr, op_idx, ir_hold, op_valid, busy, done};
    n_cmp++;
    if (obs !== 10'b00_00_00_1_0_0_0) begin
      n_fail++;
      $display("FAIL abort_reset: got %b expected %b", obs, 10'b00_00_00_1_0_0_0);
    end
    saw_done = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done || busy) saw_done++;
    end
    n_cmp++;
    if (saw_done != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", saw_done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, pm_addr} !== 3'b100) begin
      n_fail++;
      $display("FAIL abort_restart: got busy/pm=%b expected 100", {busy, pm_addr});
    end
    ops = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (op_valid) begin
        n_cmp++;
        if (mem_addr !== 2'(ops)) begin
          n_fail++;
          $display("FAIL abort_rerun_addr[%0d]: got %0d expected %0d", ops, mem_addr, ops);
        end
        ops++;
      end
    end
    n_cmp++;
    if ((done !== 1'b1) || (ops != 4)) begin
      n_fail++;
      $display("FAIL abort_rerun_end: got done=%b ops=%0d expected done=1 ops=4", done, ops);
    end
    tick();
  endtask

  task automatic test_pm_overflow();
    int ops;
    int done_cyc;
    clear_rom();
    for (int i = 0; i < 4; i++) set_rom(i, 1'b1, 2'd0, 1'b0);
    ops = 0;
    done_cyc = 0;
    start = 1'b1;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      tick();
      start = 1'b0;
      if (op_valid) ops++;
      if (done) done_cyc = c;
    end
    n_cmp++;
    if ((done_cyc != 25) || (ops != 16) || (pm_addr !== 2'd3)) begin
      n_fail++;
      $display("FAIL pm_overflow: got done_cyc=%0d ops=%0d pm=%0d expected 25 16 3", done_cyc, ops, pm_addr);
    end
    tick();
    n_cmp++;
    if ({busy, pm_addr} !== 3'b011) begin
      n_fail++;
      $display("FAIL pm_overflow_idle: got busy/pm=%b expected 011", {busy, pm_addr});
    end
  endtask

  task automatic test_start_hold_restart();
    logic [3:0] obs;
    logic [3:0] exp;
    clear_rom();
    set_rom(0, 1'b1, 2'd0, 1'b1);
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1 || c == 4) start = 1'b0;
      if (c == 3 || c == 5) start = 1'b1;
      if (c == 9) start = 1'b0;
      exp = {((c >= 3) && (c <= 6)) || ((c >= 11) && (c <= 14)),
             (c == 7) || (c == 15),
             !((c == 8) || (c == 16)),
             !((c == 2) || (c == 10))};
      obs = {op_valid, done, busy, ir_hold};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL restart_c%0d: got valid/done/busy/hold=%b expected %b", c, obs, exp);
      end
      if (obs[3] && exp[3]) begin
        n_cmp++;
        if (mem_addr !== 2'((c <= 6) ? (c - 3) : (c - 11))) begin
          n_fail++;
          $display("FAIL restart_addr_c%0d: got %0d", c, mem_addr);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    clear_rom();
    test_reset();
    test_single_up();
    test_down_two_ops();
    test_two_elements();
    test_reset_mid_run();
    test_pm_overflow();
    test_start_hold_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
